// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: registers the MEM/WB payload, issues RF and R7 write strobes,
// keeps a short history of committed GPR writes for bypass, and counts retired instructions.
module wb_commit_stage #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 3,
  parameter int unsigned PC_REG    = 7,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  output logic          in_ready,
  input  logic          reg_we,
  input  logic          r7_we,
  input  logic [AW-1:0] dest,
  input  logic [1:0]    regSelect,
  input  logic [2:0]    r7Select,
  input  logic [DW-1:0] MemData,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] Imm970,
  input  logic [DW-1:0] PCInc,
  input  logic [DW-1:0] PCImmInc,
  input  logic [DW-1:0] RFOut2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          pc_we,
  output logic [DW-1:0] pc_wdata,
  input  logic [AW-1:0] fwd_raddr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          sel_err,
  output logic [CW-1:0] retired
);

  localparam logic [AW-1:0] PcAddr = AW'(PC_REG);

  logic          r_valid;
  logic          r_reg_we;
  logic          r_r7_we;
  logic [AW-1:0] r_dest;
  logic [DW-1:0] r_rf_data;
  logic [DW-1:0] r_pc_data;
  logic          r_sel_err;
  logic [CW-1:0] r_retired;

  logic          r_hv [FWD_DEPTH];
  logic [AW-1:0] r_ha [FWD_DEPTH];
  logic [DW-1:0] r_hd [FWD_DEPTH];

  logic          w_capture;
  logic          w_rf_we;
  logic [DW-1:0] w_reg_mux;
  logic [DW-1:0] w_r7_mux;
  logic          w_r7_illegal;
  logic          w_hit;
  logic [DW-1:0] w_data;

  assign w_capture = in_valid & ~stall & ~flush;
  assign w_rf_we   = r_valid & r_reg_we & (r_dest != PcAddr);

  always_comb begin
    w_reg_mux = '0;
    unique case (regSelect)
      2'd0: w_reg_mux = MemData;
      2'd1: w_reg_mux = ALUOut;
      2'd2: w_reg_mux = Imm970;
      2'd3: w_reg_mux = PCInc;
    endcase
  end

  // Codes 6 and 7 are illegal: they load zero and raise the sticky error.
  always_comb begin
    w_r7_mux     = '0;
    w_r7_illegal = 1'b0;
    case (r7Select)
      3'd0:    w_r7_mux = Imm970;
      3'd1:    w_r7_mux = MemData;
      3'd2:    w_r7_mux = PCImmInc;
      3'd3:    w_r7_mux = ALUOut;
      3'd4:    w_r7_mux = RFOut2;
      3'd5:    w_r7_mux = PCInc;
      default: w_r7_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_reg_we  <= 1'b0;
      r_r7_we   <= 1'b0;
      r_dest    <= '0;
      r_rf_data <= '0;
      r_pc_data <= '0;
      r_sel_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_reg_we  <= reg_we;
        r_r7_we   <= r7_we;
        r_dest    <= dest;
        r_rf_data <= w_reg_mux;
        r_pc_data <= w_r7_mux;
        if (r7_we && w_r7_illegal) begin
          r_sel_err <= 1'b1;
        end
      end
      if (r_valid) begin
        r_retired <= r_retired + CW'(1);
      end
    end
  end

  // History shifts only on a committed GPR write; entry 0 is the youngest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        r_hv[i] <= 1'b0;
        r_ha[i] <= '0;
        r_hd[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_hv[0] <= 1'b1;
      r_ha[0] <= r_dest;
      r_hd[0] <= r_rf_data;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        r_hv[i] <= r_hv[i-1];
        r_ha[i] <= r_ha[i-1];
        r_hd[i] <= r_hd[i-1];
      end
    end
  end

  // Scan oldest to youngest so later (younger) matches override earlier ones.
  always_comb begin
    w_hit  = 1'b0;
    w_data = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (r_hv[i] && (r_ha[i] == fwd_raddr)) begin
        w_hit  = 1'b1;
        w_data = r_hd[i];
      end
    end
    if (w_rf_we && (r_dest == fwd_raddr)) begin
      w_hit  = 1'b1;
      w_data = r_rf_data;
    end
    if (fwd_raddr == PcAddr) begin
      w_hit  = 1'b0;
      w_data = '0;
    end
  end

  assign in_ready = ~stall;
  assign rf_we    = w_rf_we;
  assign rf_waddr = r_dest;
  assign rf_wdata = r_rf_data;
  assign pc_we    = r_valid & r_r7_we;
  assign pc_wdata = r_pc_data;
  assign fwd_hit  = w_hit;
  assign fwd_data = w_data;
  assign sel_err  = r_sel_err;
  assign retired  = r_retired;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: mux table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_wb_commit_stage;

  localparam int unsigned FWD_DEPTH = 2;
  localparam int unsigned CW = 4;

  logic        clk, reset;
  logic        in_valid, stall, flush, in_ready;
  logic        reg_we, r7_we;
  logic [2:0]  dest;
  logic [1:0]  regSelect;
  logic [2:0]  r7Select;
  logic [15:0] MemData, ALUOut, Imm970, PCInc, PCImmInc, RFOut2;
  logic        rf_we, pc_we, fwd_hit, sel_err;
  logic [2:0]  rf_waddr, fwd_raddr;
  logic [15:0] rf_wdata, pc_wdata, fwd_data;
  logic [3:0]  retired;

  wb_commit_stage #(
    .DW(16), .AW(3), .PC_REG(7), .FWD_DEPTH(FWD_DEPTH), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_ready(in_ready), .reg_we(reg_we), .r7_we(r7_we), .dest(dest),
    .regSelect(regSelect), .r7Select(r7Select), .MemData(MemData), .ALUOut(ALUOut),
    .Imm970(Imm970), .PCInc(PCInc), .PCImmInc(PCImmInc), .RFOut2(RFOut2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_we(pc_we),
    .pc_wdata(pc_wdata), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .sel_err(sel_err), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending instruction plus a youngest-first list of committed writes.
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } hent_t;

  hent_t       hist[$];
  logic        m_valid, m_reg_we, m_r7_we, m_err;
  logic [2:0]  m_dest;
  logic [15:0] m_rfd, m_pcd;
  int          m_ret;

  task automatic model_reset();
    hist.delete();
    m_valid = 0; m_reg_we = 0; m_r7_we = 0; m_err = 0;
    m_dest = 0; m_rfd = 0; m_pcd = 0; m_ret = 0;
  endtask

  function automatic logic m_commit();
    return m_valid && m_reg_we && (m_dest != 3'd7);
  endfunction

  task automatic model_step();
    logic [15:0] rs[4];
    logic [15:0] ps[6];
    hent_t e;
    rs = '{MemData, ALUOut, Imm970, PCInc};
    ps = '{Imm970, MemData, PCImmInc, ALUOut, RFOut2, PCInc};
    if (m_commit()) begin
      e.a = m_dest;
      e.d = m_rfd;
      hist.push_front(e);
      if (hist.size() > FWD_DEPTH) void'(hist.pop_back());
    end
    if (m_valid) m_ret = (m_ret + 1) % (1 << CW);
    if (in_valid && !stall && !flush) begin
      m_valid = 1; m_reg_we = reg_we; m_r7_we = r7_we; m_dest = dest;
      m_rfd = rs[regSelect];
      if (r7Select > 3'd5) begin
        m_pcd = 16'h0;
        if (r7_we) m_err = 1;
      end else begin
        m_pcd = ps[r7Select];
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_model();
    logic        eh;
    logic [15:0] ed;
    eh = 0; ed = 0;
    if (fwd_raddr != 3'd7) begin
      if (m_commit() && m_dest == fwd_raddr) begin
        eh = 1; ed = m_rfd;
      end else begin
        foreach (hist[i]) begin
          if (!eh && hist[i].a == fwd_raddr) begin
            eh = 1; ed = hist[i].d;
          end
        end
      end
    end
    chk("m_rf_we", rf_we, m_commit());
    chk("m_rf_waddr", rf_waddr, m_dest);
    chk("m_rf_wdata", rf_wdata, m_rfd);
    chk("m_pc_we", pc_we, m_valid && m_r7_we);
    chk("m_pc_wdata", pc_wdata, m_pcd);
    chk("m_fwd_hit", fwd_hit, eh);
    chk("m_fwd_data", fwd_data, ed);
    chk("m_sel_err", sel_err, m_err);
    chk("m_retired", retired, m_ret);
    chk("m_in_ready", in_ready, !stall);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; stall = 0; flush = 0; reg_we = 0; r7_we = 0;
    dest = 0; regSelect = 0; r7Select = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    set_idle();
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_pc_wdata", pc_wdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_retired", retired, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    set_idle();
    in_valid = 1; reg_we = 1; dest = a; regSelect = 2'd1; ALUOut = d;
    cycle();
  endtask

  task automatic idle();
    set_idle();
    cycle();
  endtask

  typedef struct {
    logic        reg_we;
    logic        r7_we;
    logic [2:0]  dest;
    logic [1:0]  rsel;
    logic [2:0]  psel;
    logic        e_rf_we;
    logic [15:0] e_rf_wdata;
    logic        e_pc_we;
    logic [15:0] e_pc_wdata;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [3:0] r_exp;
    tbl[0] = '{1, 0, 3'd1, 2'd0, 3'd0, 1, 16'h1111, 0, 16'h3333};
    tbl[1] = '{1, 0, 3'd2, 2'd1, 3'd1, 1, 16'h2222, 0, 16'h1111};
    tbl[2] = '{1, 1, 3'd3, 2'd2, 3'd2, 1, 16'h3333, 1, 16'h0040};
    tbl[3] = '{0, 1, 3'd4, 2'd3, 3'd3, 0, 16'h4444, 1, 16'h2222};
    tbl[4] = '{1, 1, 3'd7, 2'd0, 3'd4, 0, 16'h1111, 1, 16'h6666};
    tbl[5] = '{1, 1, 3'd6, 2'd1, 3'd5, 1, 16'h2222, 1, 16'h4444};
    tbl[6] = '{1, 1, 3'd7, 2'd1, 3'd2, 0, 16'h2222, 1, 16'h0040};
    tbl[7] = '{0, 1, 3'd5, 2'd2, 3'd7, 0, 16'h3333, 1, 16'h0000};

    MemData = 16'h1111; ALUOut = 16'h2222; Imm970 = 16'h3333;
    PCInc = 16'h4444; PCImmInc = 16'h0040; RFOut2 = 16'h6666;
    fwd_raddr = 0;
    do_reset();

    // First commit: one-cycle strobe, retired counts after it.
    wr(3'd3, 16'h1234);
    chk("first_rf_we", rf_we, 1);
    chk("first_waddr", rf_waddr, 3);
    chk("first_wdata", rf_wdata, 16'h1234);
    idle();
    chk("first_strobe_drop", rf_we, 0);
    chk("first_retired", retired, 1);

    ALUOut = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      set_idle();
      in_valid = 1; reg_we = tbl[i].reg_we; r7_we = tbl[i].r7_we; dest = tbl[i].dest;
      regSelect = tbl[i].rsel; r7Select = tbl[i].psel;
      cycle();
      chk($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].e_rf_we);
      chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_rf_wdata);
      chk($sformatf("tbl%0d_pc_we", i), pc_we, tbl[i].e_pc_we);
      chk($sformatf("tbl%0d_pc_wdata", i), pc_wdata, tbl[i].e_pc_wdata);
      chk($sformatf("tbl%0d_sel_err", i), sel_err, (i == 7) ? 1 : 0);
    end
    idle();
    chk("tbl_pc_we_drop", pc_we, 0);
    idle();
    chk("sel_err_sticky", sel_err, 1);

    do_reset();
    // Youngest of two writes to r2 wins; two further writes age it out.
    wr(3'd2, 16'h0001);
    wr(3'd2, 16'h0002);
    wr(3'd5, 16'h0055);
    fwd_raddr = 3'd2; #1;
    chk("fwd_young_hit", fwd_hit, 1);
    chk("fwd_young_data", fwd_data, 16'h0002);
    fwd_raddr = 3'd5; #1;
    chk("fwd_live_hit", fwd_hit, 1);
    chk("fwd_live_data", fwd_data, 16'h0055);
    wr(3'd1, 16'h0011);
    wr(3'd3, 16'h0033);
    fwd_raddr = 3'd2; #1;
    chk("fwd_aged_hit", fwd_hit, 0);
    chk("fwd_aged_data", fwd_data, 0);
    idle();
    idle();

    // Stall holds off capture; retired frozen.
    r_exp = 4'(m_ret);
    set_idle();
    in_valid = 1; stall = 1; reg_we = 1; dest = 3'd4; ALUOut = 16'hdead;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rf_we", rf_we, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_retired", retired, r_exp);
    end
    // Flush kills the instruction and leaves the history alone.
    stall = 0; flush = 1;
    cycle();
    chk("flush_rf_we", rf_we, 0);
    fwd_raddr = 3'd4; #1;
    chk("flush_no_hist", fwd_hit, 0);
    idle();
    fwd_raddr = 3'd3; #1;
    chk("flush_hist_kept", fwd_data, 16'h0033);
    stall = 1; flush = 1; in_valid = 1;
    cycle();
    chk("flush_stall_bubble", rf_we, 0);

    // Reset in the middle of a live write.
    wr(3'd6, 16'h0066);
    chk("mid_rf_we", rf_we, 1);
    fwd_raddr = 3'd6;
    do_reset();

    // Counter wraps after 2^CW commits.
    set_idle();
    in_valid = 1;
    for (int i = 0; i < 16; i++) cycle();
    chk("wrap_pre", retired, 15);
    idle();
    chk("wrap_zero", retired, 0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      reg_we = 1'($urandom);
      r7_we = 1'($urandom);
      dest = 3'($urandom);
      regSelect = 2'($urandom);
      r7Select = 3'($urandom);
      MemData = 16'($urandom); ALUOut = 16'($urandom); Imm970 = 16'($urandom);
      PCInc = 16'($urandom); PCImmInc = 16'($urandom); RFOut2 = 16'($urandom);
      fwd_raddr = 3'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
